// File: rtl/bip_report_pkg.sv
// Shared types and constants for the BIP post-halt report transmitter.
package bip_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } report_state_t;

    localparam logic [7:0] REPORT_HEADER = 8'hA5;
    localparam int         FRAME_LEN     = 7;
    localparam int         IDX_BITS      = 3;

endpackage

// File: rtl/bip_report_tx_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_r;

    // Count enabled edges, stopping at the maximum value.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (i_enable && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = count_r;

endmodule

// File: rtl/bip_report_tx.sv
// Counts CPU run cycles, snapshots acc/pc/count on halt and streams a
// 7-byte report frame to the UART transmitter, one byte per tx_done.
module bip_report_tx
    import bip_report_pkg::*;
#(
    parameter int E_BITS   = 16,
    parameter int PC_BITS  = 11,
    parameter int CNT_BITS = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [E_BITS-1:0]  i_acc,
    input  logic [PC_BITS-1:0] i_pc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    report_state_t       state_r;
    logic [IDX_BITS-1:0] idx_r;
    logic [15:0]         acc_r;
    logic [15:0]         pc_r;
    logic [15:0]         cnt_r;
    logic [7:0]          tx_data_r;
    logic                tx_start_r;
    logic                busy_r;
    logic                done_r;

    logic [CNT_BITS-1:0] count_s;
    logic                cnt_en_s;
    logic [IDX_BITS-1:0] next_idx_s;
    logic [7:0]          next_byte_s;
    logic                last_byte_s;

    assign cnt_en_s    = (state_r == ST_IDLE) && !i_halt;
    assign last_byte_s = (idx_r == IDX_BITS'(FRAME_LEN - 1));

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_cycle_cnt (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (cnt_en_s),
        .o_count  (count_s)
    );

    // Pick the byte for the next SEND; header comes first so it never
    // depends on the snapshot that is being latched on the same edge.
    always_comb begin
        next_idx_s  = {IDX_BITS{1'b0}};
        next_byte_s = 8'h00;
        if (state_r == ST_IDLE) begin
            next_idx_s = {IDX_BITS{1'b0}};
        end else begin
            next_idx_s = idx_r + {{(IDX_BITS-1){1'b0}}, 1'b1};
        end
        case (next_idx_s)
            3'd0:    next_byte_s = REPORT_HEADER;
            3'd1:    next_byte_s = acc_r[15:8];
            3'd2:    next_byte_s = acc_r[7:0];
            3'd3:    next_byte_s = pc_r[15:8];
            3'd4:    next_byte_s = pc_r[7:0];
            3'd5:    next_byte_s = cnt_r[15:8];
            3'd6:    next_byte_s = cnt_r[7:0];
            default: next_byte_s = 8'h00;
        endcase
    end

    // Report FSM with snapshot registers and registered handshake outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_BITS{1'b0}};
            acc_r      <= 16'h0000;
            pc_r       <= 16'h0000;
            cnt_r      <= 16'h0000;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_halt) begin
                        acc_r      <= 16'(i_acc);
                        pc_r       <= 16'(i_pc);
                        cnt_r      <= 16'(count_s);
                        idx_r      <= {IDX_BITS{1'b0}};
                        tx_data_r  <= next_byte_s;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (last_byte_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r      <= next_idx_s;
                            tx_data_r  <= next_byte_s;
                            tx_start_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_start = tx_start_r;
    assign o_tx_data  = tx_data_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_bip_report_tx.sv
// Directed bench for bip_report_tx: table of halt scenarios plus hand-written
// sequences for stray tx_done, mid-frame reset and reset-with-halt.
module tb_bip_report_tx;

    localparam int ACK_DELAY = 20;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_halt = 1'b0;
    logic [15:0] i_acc = 16'h0000;
    logic [10:0] i_pc = 11'h000;
    logic        i_tx_done = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          low_edges;
        logic [15:0] acc;
        logic [10:0] pc;
        logic [55:0] frame;
    } vec_t;

    vec_t vecs [5];

    bip_report_tx #(
        .E_BITS   (16),
        .PC_BITS  (11),
        .CNT_BITS (16)
    ) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_halt     (i_halt),
        .i_acc      (i_acc),
        .i_pc       (i_pc),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold reset for two edges, release, and check the reset state.
    task automatic do_reset();
        i_reset   = 1'b1;
        i_halt    = 1'b0;
        i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        check("reset_start", 32'(o_tx_start), 32'd0);
        check("reset_data",  32'(o_tx_data),  32'h00);
        check("reset_busy",  32'(o_busy),     32'd0);
        check("reset_done",  32'(o_done),     32'd0);
    endtask

    // Raise halt for one edge, then scramble inputs to prove the snapshot is frozen.
    task automatic start_halt(input logic [15:0] acc, input logic [10:0] pc);
        i_halt = 1'b1;
        i_acc  = acc;
        i_pc   = pc;
        @(negedge clk);
        i_halt = 1'b0;
        i_acc  = ~acc;
        i_pc   = ~pc;
    endtask

    // Check and acknowledge n_bytes of the frame; a full frame also checks completion.
    task automatic check_frame(input string tag, input logic [55:0] frame, input int n_bytes);
        logic [7:0] exp_b;
        logic       hold_ok;
        for (int b = 0; b < n_bytes; b++) begin
            exp_b = frame[55 - 8*b -: 8];
            check({tag, "_start"}, 32'(o_tx_start), 32'd1);
            check({tag, "_byte"},  32'(o_tx_data),  32'(exp_b));
            check({tag, "_busy"},  32'(o_busy),     32'd1);
            hold_ok = 1'b1;
            repeat (ACK_DELAY - 1) begin
                @(negedge clk);
                hold_ok &= (o_tx_start == 1'b0) && (o_tx_data == exp_b) && (o_busy == 1'b1) && (o_done == 1'b0);
                i_acc  = ~i_acc;
                i_pc   = ~i_pc;
                i_halt = ~i_halt;
            end
            check({tag, "_hold"}, 32'(hold_ok), 32'd1);
            @(negedge clk);
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
        end
        if (n_bytes == 7) begin
            check({tag, "_end_start"}, 32'(o_tx_start), 32'd0);
            check({tag, "_end_busy"},  32'(o_busy),     32'd0);
            check({tag, "_end_done"},  32'(o_done),     32'd1);
        end
    endtask

    initial begin
        logic quiet_ok;

        vecs[0] = '{10,    16'h1234, 11'h02A, 56'hA5_1234_002A_000A};
        vecs[1] = '{0,     16'hFFFF, 11'h7FF, 56'hA5_FFFF_07FF_0000};
        vecs[2] = '{3,     16'h00C3, 11'h400, 56'hA5_00C3_0400_0003};
        vecs[3] = '{255,   16'hABCD, 11'h100, 56'hA5_ABCD_0100_00FF};
        vecs[4] = '{70000, 16'h0001, 11'h001, 56'hA5_0001_0001_FFFF};

        @(negedge clk);
        for (int v = 0; v < 5; v++) begin
            do_reset();
            repeat (vecs[v].low_edges) @(negedge clk);
            start_halt(vecs[v].acc, vecs[v].pc);
            check_frame($sformatf("vec%0d", v), vecs[v].frame, 7);
        end

        // Stray tx_done in IDLE and in DONE must be ignored.
        do_reset();
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        check("idle_done_start", 32'(o_tx_start), 32'd0);
        check("idle_done_busy",  32'(o_busy),     32'd0);
        repeat (3) @(negedge clk);
        start_halt(16'h5A5A, 11'h123);
        check_frame("idle_ack", 56'hA5_5A5A_0123_0004, 7);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        @(negedge clk);
        check("done_ack_start", 32'(o_tx_start), 32'd0);
        check("done_ack_done",  32'(o_done),     32'd1);
        check("done_ack_busy",  32'(o_busy),     32'd0);
        check("done_ack_data",  32'(o_tx_data),  32'h04);

        // Reset while waiting on the third byte aborts the frame and clears the counter.
        do_reset();
        repeat (7) @(negedge clk);
        start_halt(16'h0BEE, 11'h0AA);
        check_frame("pre_abort", 56'hA5_0BEE_00AA_0007, 2);
        check("abort_b3_start", 32'(o_tx_start), 32'd1);
        check("abort_b3_byte",  32'(o_tx_data),  32'hEE);
        @(negedge clk);
        i_reset = 1'b1;
        i_halt  = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        check("abort_busy",  32'(o_busy),     32'd0);
        check("abort_start", 32'(o_tx_start), 32'd0);
        check("abort_data",  32'(o_tx_data),  32'h00);
        check("abort_done",  32'(o_done),     32'd0);
        quiet_ok = 1'b1;
        i_tx_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            i_tx_done = 1'b0;
            quiet_ok &= (o_tx_start == 1'b0) && (o_busy == 1'b0);
        end
        check("abort_quiet", 32'(quiet_ok), 32'd1);
        start_halt(16'h0042, 11'h7FE);
        check_frame("post_abort", 56'hA5_0042_07FE_000C, 7);

        // Reset and halt on the same edge: reset wins, next halt edge latches count 0.
        i_reset = 1'b1;
        i_halt  = 1'b1;
        @(negedge clk);
        check("rsthalt_start", 32'(o_tx_start), 32'd0);
        check("rsthalt_busy",  32'(o_busy),     32'd0);
        check("rsthalt_done",  32'(o_done),     32'd0);
        i_reset = 1'b0;
        start_halt(16'h00FF, 11'h001);
        check_frame("rsthalt", 56'hA5_00FF_0001_0000, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
